// File: rtl/ups_ctrl_pkg.sv
// Shared definitions for the x4 up-sampler timing controller:
// state encoding, default divide ratios and counter width helper.
package ups_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } ups_state_e;

   localparam int unsigned DEF_CLK_PER_SAM   = 4;
   localparam int unsigned DEF_SAM_PER_SYM   = 4;
   localparam int unsigned DEF_ALIGN_TIMEOUT = 1023;

   // Bits needed to hold 0..n-1; never less than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ups_mod_cnt.sv
// Modulo-N counter with enable, synchronous clear and wrap pulse.
// cnt_nxt exposes the value that will be loaded at the next edge so the
// parent can register outputs that line up with the counter itself.
module ups_mod_cnt
   import ups_ctrl_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = cnt_w(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic [W-1:0] cnt_nxt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   // Next-count: clear wins, otherwise count and wrap at N-1.
   always_comb begin
      wrap    = en && (cnt == LAST);
      cnt_nxt = cnt;
      if (clr)
         cnt_nxt = '0;
      else if (en)
         cnt_nxt = wrap ? '0 : cnt + W'(1);
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

endmodule

// File: rtl/ups_timing_ctrl.sv
// Timing/sequencing controller for the x4 up-sampler: sample strobe sam_clk,
// symbol strobe sym_clk (coincident with sam_clk at phase 0), start/stop
// sequencing, frame-sync alignment and lock/error status.
// Optional feature: define UPS_PHASE_ADJ_EN to add the slip input, which
// stretches one sample period by a clk to retard the sample grid.
module ups_timing_ctrl
   import ups_ctrl_pkg::*;
#(
   parameter int unsigned CLK_PER_SAM   = DEF_CLK_PER_SAM,
   parameter int unsigned SAM_PER_SYM   = DEF_SAM_PER_SYM,
   parameter int unsigned ALIGN_TIMEOUT = DEF_ALIGN_TIMEOUT,
   localparam int unsigned PW = cnt_w(SAM_PER_SYM)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic          align_in,
   output logic          sam_clk,
   output logic          sym_clk,
   output logic [PW-1:0] ups_phase,
   output logic          busy,
   output logic          locked,
   output logic          align_err
`ifdef UPS_PHASE_ADJ_EN
   ,
   input  logic          slip
`endif
);

   localparam int unsigned CW = cnt_w(CLK_PER_SAM);
   localparam int unsigned TW = cnt_w(ALIGN_TIMEOUT + 1);
   localparam logic [CW-1:0] CLK_LAST = CW'(CLK_PER_SAM - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(ALIGN_TIMEOUT);

   ups_state_e    st_q, st_nxt;
   logic [TW-1:0] tmo_q, tmo_nxt;
   logic [CW-1:0] clk_cnt, clk_cnt_nxt;
   logic [PW-1:0] ph_cnt, ph_cnt_nxt;
   logic          clk_wrap, ph_wrap;
   logic          act_q, act_nxt;
   logic          cnt_clr, cnt_en;
   logic          slip_req, slip_acc, hold, pend_q, pend_nxt;
   logic          err_nxt, sam_nxt, sym_nxt;

`ifdef UPS_PHASE_ADJ_EN
   assign slip_req = slip;
`else
   assign slip_req = 1'b0;
`endif

   // Next state, sticky error and ALIGN timeout; stop outranks start/align_in.
   always_comb begin
      st_nxt  = st_q;
      err_nxt = align_err;
      case (st_q)
         ST_IDLE:
            if (start && !stop) begin
               st_nxt  = ST_ALIGN;
               err_nxt = 1'b0;
            end
         ST_ALIGN:
            if (stop)
               st_nxt = ST_IDLE;
            else if (align_in)
               st_nxt = ST_RUN;
            else if (tmo_q == TMO_MAX) begin
               st_nxt  = ST_RUN;
               err_nxt = 1'b1;
            end
         ST_RUN:
            if (stop)
               st_nxt = ST_DRAIN;
         ST_DRAIN:
            // Last clk of the last sample of the symbol.
            if (ph_wrap)
               st_nxt = ST_IDLE;
         default:
            st_nxt = ST_IDLE;
      endcase
      tmo_nxt = (st_q == ST_ALIGN && st_nxt == ST_ALIGN) ? tmo_q + TW'(1) : '0;
   end

   // Grid control: a slip is parked until the final clk of the current
   // sample and then holds clk_cnt there once, so the period is CLK_PER_SAM+1
   // and no duplicate clk_cnt==0 cycle is ever produced.
   always_comb begin
      act_q    = (st_q == ST_RUN) || (st_q == ST_DRAIN);
      act_nxt  = (st_nxt == ST_RUN) || (st_nxt == ST_DRAIN);
      slip_acc = slip_req && (st_q == ST_RUN) && !pend_q;
      hold     = (st_q == ST_RUN) && (pend_q || slip_acc) && (clk_cnt == CLK_LAST);
      pend_nxt = (st_nxt == ST_RUN) && (pend_q || slip_acc) && !hold;
      cnt_en   = act_q && !hold;
      cnt_clr  = !act_nxt;
      // hold matters here only for CLK_PER_SAM==1, where the held count is 0.
      sam_nxt  = act_nxt && (clk_cnt_nxt == '0) && !hold;
      sym_nxt  = (st_nxt == ST_RUN) && sam_nxt && (ph_cnt_nxt == '0);
   end

   // State, timeout and slip-pending registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q   <= ST_IDLE;
         tmo_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         st_q   <= st_nxt;
         tmo_q  <= tmo_nxt;
         pend_q <= pend_nxt;
      end
   end

   // Registered outputs, loaded from next-state values so they line up
   // with the state/counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sam_clk   <= 1'b0;
         sym_clk   <= 1'b0;
         busy      <= 1'b0;
         locked    <= 1'b0;
         align_err <= 1'b0;
      end else begin
         sam_clk   <= sam_nxt;
         sym_clk   <= sym_nxt;
         busy      <= (st_nxt != ST_IDLE);
         locked    <= (st_nxt == ST_RUN);
         align_err <= err_nxt;
      end
   end

   assign ups_phase = ph_cnt;

   ups_mod_cnt #(.N(CLK_PER_SAM), .W(CW)) u_clk_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .cnt     (clk_cnt),
      .cnt_nxt (clk_cnt_nxt),
      .wrap    (clk_wrap)
   );

   ups_mod_cnt #(.N(SAM_PER_SYM), .W(PW)) u_ph_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (cnt_clr),
      .en      (clk_wrap),
      .cnt     (ph_cnt),
      .cnt_nxt (ph_cnt_nxt),
      .wrap    (ph_wrap)
   );

endmodule
